ghash_ctrl: RTL and testbench

GHASH sequencing controller for the AES-GCM datapath, sitting directly upstream of the `gfmul_v2` GF(2^128) multiplier. It accepts padded AAD and ciphertext blocks over a valid/ready handshake and folds each block into the running hash (Y = (Y ⊕ X) · H). After the last data block it appends the GCM length block and emits the final GHASH value S for tag generation. It owns one `gfmul_v2` instance and drives that instance's operand and valid handshake.

---
 rtl/gcm_pkg.sv | 19 +
 rtl/ghash_ctrl_if.sv | 13 +
 rtl/gfmul_v2.sv | 74 +++++++
 rtl/ghash_ctrl.sv | 118 +++++++++++
 tb/tb_ghash_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block/length widths, GHASH FSM encoding, zero block.
package gcm_pkg;

  localparam int BLK_W = 128;
  localparam int LEN_W = 64;

  typedef logic [0:BLK_W-1] gcm_blk_t;

  localparam gcm_blk_t GCM_ZERO_BLK = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    MUL      = 3'd2,
    LEN      = 3'd3,
    MUL_LEN  = 3'd4
  } ghash_state_t;

endpackage

// File: rtl/ghash_ctrl_if.sv
// Data-block stream into the GHASH controller (valid/ready, last-qualified).
interface ghash_ctrl_if;
  import gcm_pkg::*;

  logic [BLK_W-1:0] iBlock;
  logic             iBlock_valid;
  logic             iBlock_last;
  logic             oBlock_ready;

  modport master (output iBlock, iBlock_valid, iBlock_last, input oBlock_ready);
  modport slave  (input iBlock, iBlock_valid, iBlock_last, output oBlock_ready);

endinterface

// File: rtl/gfmul_v2.sv
// Iterative GF(2^128) multiplier in GCM bit order, 4 bits of the data operand
// per cycle. oResult_valid rises after the product is ready and stays high
// until the requester drops its valids; the unit then re-arms.
module gfmul_v2
  import gcm_pkg::*;
(
  input  logic     iClk,
  input  logic     iRstn,
  input  gcm_blk_t iCtext,
  input  logic     iCtext_valid,
  input  gcm_blk_t iHashkey,
  input  logic     iHashkey_valid,
  output gcm_blk_t oResult,
  output logic     oResult_valid
);

  localparam int       BITS_PER_CYC = 4;
  localparam int       STEPS        = BLK_W / BITS_PER_CYC;
  localparam gcm_blk_t GF_R         = {8'hE1, 120'h0};

  gcm_blk_t   z_q, v_q, x_q;
  gcm_blk_t   z_d, v_d, x_d;
  logic [4:0] cnt_q;
  logic       busy_q, done_q;
  logic       req;

  assign req = iCtext_valid && iHashkey_valid;

  // Shift-and-add over BITS_PER_CYC data bits; V is reduced by R whenever its
  // last bit falls off (bit 0 is the GCM MSB, so >> is multiply-by-x).
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    x_d = x_q;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (x_d[0]) z_d = z_d ^ v_d;
      v_d = v_d[BLK_W-1] ? ((v_d >> 1) ^ GF_R) : (v_d >> 1);
      x_d = x_d << 1;
    end
  end

  // Load on request, iterate STEPS cycles, hold result until the request drops.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      z_q    <= GCM_ZERO_BLK;
      v_q    <= GCM_ZERO_BLK;
      x_q    <= GCM_ZERO_BLK;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (busy_q) begin
      z_q   <= z_d;
      v_q   <= v_d;
      x_q   <= x_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(STEPS - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else if (done_q) begin
      if (!req) done_q <= 1'b0;
    end else if (req) begin
      z_q    <= GCM_ZERO_BLK;
      v_q    <= iHashkey;
      x_q    <= iCtext;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end
  end

  assign oResult       = z_q;
  assign oResult_valid = done_q;

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds data blocks into Y = (Y ^ X) * H, then the length
// block, and publishes S. All outputs are registered.
module ghash_ctrl
  import gcm_pkg::*;
(
  input  logic             iClk,
  input  logic             iRstn,
  input  gcm_blk_t         iHashkey,
  input  logic             iStart,
  input  logic [LEN_W-1:0] iLen_aad,
  input  logic [LEN_W-1:0] iLen_ctext,
  ghash_ctrl_if.slave      blk,
  output gcm_blk_t         oGhash,
  output logic             oGhash_valid,
  output logic             oBusy
);

  ghash_state_t state_q;
  gcm_blk_t     y_q, a_q, h_q, len_q, ghash_q;
  logic         last_q, mul_vld_q, rdy_q, busy_q, ghash_vld_q;

  gcm_blk_t     mul_res;
  logic         mul_res_vld;
  gcm_blk_t     blk_xor, len_xor;

  assign blk_xor = y_q ^ blk.iBlock;
  assign len_xor = y_q ^ len_q;

  gfmul_v2 u_mul (
    .iClk           (iClk),
    .iRstn          (iRstn),
    .iCtext         (a_q),
    .iCtext_valid   (mul_vld_q),
    .iHashkey       (h_q),
    .iHashkey_valid (mul_vld_q),
    .oResult        (mul_res),
    .oResult_valid  (mul_res_vld)
  );

  // Sequencer FSM; mul_vld_q drops on the result cycle and is re-raised only
  // from WAIT_BLK/LEN, which guarantees a valid-low gap between multiplies.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q     <= IDLE;
      y_q         <= GCM_ZERO_BLK;
      a_q         <= GCM_ZERO_BLK;
      h_q         <= GCM_ZERO_BLK;
      len_q       <= GCM_ZERO_BLK;
      ghash_q     <= GCM_ZERO_BLK;
      last_q      <= 1'b0;
      mul_vld_q   <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      ghash_vld_q <= 1'b0;
    end else begin
      ghash_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            h_q    <= iHashkey;
            len_q  <= {iLen_aad, iLen_ctext};
            y_q    <= GCM_ZERO_BLK;
            busy_q <= 1'b1;
            if (iLen_aad == '0 && iLen_ctext == '0) begin
              state_q <= LEN;
            end else begin
              state_q <= WAIT_BLK;
              rdy_q   <= 1'b1;
            end
          end
        end
        WAIT_BLK: begin
          if (blk.iBlock_valid) begin
            a_q       <= blk_xor;
            last_q    <= blk.iBlock_last;
            rdy_q     <= 1'b0;
            mul_vld_q <= 1'b1;
            state_q   <= MUL;
          end
        end
        MUL: begin
          if (mul_res_vld) begin
            y_q       <= mul_res;
            mul_vld_q <= 1'b0;
            if (last_q) begin
              state_q <= LEN;
            end else begin
              state_q <= WAIT_BLK;
              rdy_q   <= 1'b1;
            end
          end
        end
        LEN: begin
          a_q       <= len_xor;
          mul_vld_q <= 1'b1;
          state_q   <= MUL_LEN;
        end
        MUL_LEN: begin
          if (mul_res_vld) begin
            y_q         <= mul_res;
            ghash_q     <= mul_res;
            ghash_vld_q <= 1'b1;
            mul_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk.oBlock_ready = rdy_q;
  assign oGhash           = ghash_q;
  assign oGhash_valid     = ghash_vld_q;
  assign oBusy            = busy_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: polynomial-arithmetic GHASH model, per-cycle compare
// of multiplier products / final S / handshake rules, and directed messages.
module tb_ghash_ctrl;

  logic          clk;
  logic          iRstn;
  logic [127:0]  iHashkey;
  logic          iStart;
  logic [63:0]   iLen_aad, iLen_ctext;
  logic [127:0]  oGhash;
  logic          oGhash_valid, oBusy;

  ghash_ctrl_if blk_if();

  ghash_ctrl dut (
    .iClk         (clk),
    .iRstn        (iRstn),
    .iHashkey     (iHashkey),
    .iStart       (iStart),
    .iLen_aad     (iLen_aad),
    .iLen_ctext   (iLen_ctext),
    .blk          (blk_if.slave),
    .oGhash       (oGhash),
    .oGhash_valid (oGhash_valid),
    .oBusy        (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int rdy_cnt = 0;

  logic [127:0] exp_prod[$];
  logic [127:0] exp_ghash[$];
  logic [127:0] model_y, model_h, model_len;

  localparam logic [127:0] H1  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] C1  = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [127:0] S1  = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
  localparam logic [127:0] H2  = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [127:0] B1  = 128'hD609B1F056637A0D46DF998D88E52E00;
  localparam logic [127:0] B2  = 128'hB2C2846512153524C0895E8100000000;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // GHASH product as polynomials: bit i from the left is the x^i coefficient;
  // carry-less multiply, then reduce with x^128 = x^7 + x^2 + x + 1.
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] h);
    logic [254:0] p;
    logic [127:0] r;
    p = '0;
    for (int i = 0; i < 128; i++)
      if (x[127-i])
        for (int j = 0; j < 128; j++)
          if (h[127-j]) p[i+j] = ~p[i+j];
    for (int k = 254; k >= 128; k--)
      if (p[k]) begin
        p[k]     = 1'b0;
        p[k-128] = ~p[k-128];
        p[k-127] = ~p[k-127];
        p[k-126] = ~p[k-126];
        p[k-121] = ~p[k-121];
      end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  task automatic finish_model();
    model_y = gmul(model_y ^ model_len, model_h);
    exp_prod.push_back(model_y);
    exp_ghash.push_back(model_y);
  endtask

  task automatic start_msg(input logic [127:0] h, input logic [63:0] la, input logic [63:0] lc);
    @(negedge clk);
    iHashkey = h; iLen_aad = la; iLen_ctext = lc; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    chk("busy_rises", oBusy, 1);
    model_h = h; model_y = '0; model_len = {la, lc};
    if (la == 0 && lc == 0) finish_model();
  endtask

  task automatic send_blk(input logic [127:0] b, input logic lst);
    int n = 0;
    @(negedge clk);
    blk_if.iBlock = b; blk_if.iBlock_valid = 1'b1; blk_if.iBlock_last = lst;
    while (!blk_if.oBlock_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!blk_if.oBlock_ready) begin
      fail("blk_accept_timeout");
      blk_if.iBlock_valid = 1'b0;
      return;
    end
    @(negedge clk);
    blk_if.iBlock_valid = 1'b0; blk_if.iBlock_last = 1'b0;
    model_y = gmul(model_y ^ b, model_h);
    exp_prod.push_back(model_y);
    if (lst) finish_model();
  endtask

  task automatic wait_done(output logic [127:0] g);
    int n = 0;
    g = '0;
    while (!oGhash_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!oGhash_valid) begin
      fail("ghash_timeout");
      return;
    end
    g = oGhash;
    chk("busy_falls_with_valid", oBusy, 0);
    @(negedge clk);
    chk("ghash_valid_pulse", oGhash_valid, 0);
    chk("ghash_holds", oGhash, g);
  endtask

  // Per-cycle compare against the model queues and handshake rules.
  initial begin
    logic         prev_rv, prev_mv;
    logic [127:0] prev_a, prev_h;
    prev_rv = 1'b0; prev_mv = 1'b0; prev_a = '0; prev_h = '0;
    forever begin
      @(negedge clk);
      if (!iRstn) begin
        prev_rv = 1'b0; prev_mv = 1'b0;
      end else begin
        if (dut.mul_res_vld && !prev_rv) begin
          if (exp_prod.size() == 0) fail("unexpected_product");
          else chk("product_y", dut.mul_res, exp_prod.pop_front());
        end
        if (oGhash_valid) begin
          if (exp_ghash.size() == 0) fail("unexpected_ghash");
          else chk("ghash_s", oGhash, exp_ghash.pop_front());
        end
        if (dut.mul_vld_q && prev_mv) begin
          chk("operand_a_stable", dut.a_q, prev_a);
          chk("operand_h_stable", dut.h_q, prev_h);
        end
        if (blk_if.oBlock_ready) begin
          rdy_cnt++;
          chk("ready_implies_busy", oBusy, 1);
        end
        prev_rv = dut.mul_res_vld;
        prev_mv = dut.mul_vld_q;
        prev_a  = dut.a_q;
        prev_h  = dut.h_q;
      end
    end
  end

  initial begin
    logic [127:0] g;
    int r0;
    iRstn = 1'b0; iStart = 1'b0; iHashkey = '0; iLen_aad = '0; iLen_ctext = '0;
    blk_if.iBlock = '0; blk_if.iBlock_valid = 1'b0; blk_if.iBlock_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ghash", oGhash, 0);
    chk("rst_ghash_valid", oGhash_valid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", blk_if.oBlock_ready, 0);
    iRstn = 1'b1;

    // Pin the model to published values.
    chk("model_tc2_y", gmul(C1, H1), 128'h5E2EC746917062882C85B0685353DEB7);
    chk("model_tc2_s", gmul(128'h5E2EC746917062882C85B0685353DEB7 ^ 128'h80, H1), S1);
    chk("model_2blk_y1", gmul(B1, H2), 128'h9CABBD91899C1413AA7AD629C1DF12CD);
    chk("model_2blk_y2", gmul(128'h9CABBD91899C1413AA7AD629C1DF12CD ^ B2, H2),
        128'hB99ABF6BDBD18B8E148F8030F0686F28);

    // Empty message goes straight to the length block.
    r0 = rdy_cnt;
    start_msg(H1, 64'd0, 64'd0);
    wait_done(g);
    chk("empty_ghash", g, 0);
    chk("empty_no_wait_blk", 128'(rdy_cnt), 128'(r0));

    // GCM test case 2.
    start_msg(H1, 64'd0, 64'd128);
    send_blk(C1, 1'b1);
    wait_done(g);
    chk("tc2_ghash", g, S1);

    // Two blocks, with junk held on the bus while the first multiply runs.
    start_msg(H2, 64'd224, 64'd0);
    send_blk(B1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      blk_if.iBlock = {$urandom, $urandom, $urandom, $urandom};
      blk_if.iBlock_valid = 1'b1;
      @(negedge clk);
      chk("bp_ready_low", blk_if.oBlock_ready, 0);
    end
    blk_if.iBlock_valid = 1'b0;
    send_blk(B2, 1'b1);
    wait_done(g);
    chk("two_blk_y2_model", model_y, gmul(128'hB99ABF6BDBD18B8E148F8030F0686F28 ^ {64'd224, 64'd0}, H2));

    // Reset while the data multiply is in flight, then rerun test case 2.
    start_msg(H1, 64'd0, 64'd128);
    send_blk(C1, 1'b1);
    repeat (5) @(negedge clk);
    #1 iRstn = 1'b0;
    exp_prod.delete();
    exp_ghash.delete();
    @(negedge clk);
    chk("midrst_ghash", oGhash, 0);
    chk("midrst_ghash_valid", oGhash_valid, 0);
    chk("midrst_busy", oBusy, 0);
    chk("midrst_ready", blk_if.oBlock_ready, 0);
    chk("midrst_mul_valid", dut.mul_vld_q, 0);
    #1 iRstn = 1'b1;
    start_msg(H1, 64'd0, 64'd128);
    send_blk(C1, 1'b1);
    wait_done(g);
    chk("rerun_tc2_ghash", g, S1);

    // A second start while busy must be ignored.
    start_msg(H1, 64'd0, 64'd128);
    @(negedge clk);
    iHashkey = H2; iLen_aad = 64'd0; iLen_ctext = 64'd0; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    chk("busy_start_ready", blk_if.oBlock_ready, 1);
    send_blk(C1, 1'b1);
    wait_done(g);
    chk("busy_start_ghash", g, S1);

    repeat (5) @(negedge clk);
    chk("prod_queue_empty", 128'(exp_prod.size()), 0);
    chk("ghash_queue_empty", 128'(exp_ghash.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
